cnn_layer_scheduler: RTL and testbench
======================================

Name: cnn_layer_scheduler

Overview:
- Sequences the CNN engine chain (pool, depthwise/pointwise conv, later layers) for one inference run.
- Each layer engine has a start/done handshake. Layers run strictly in index order.
- The scheduler issues one-cycle start pulses, waits for the active layer's done pulse, skips masked-off layers, enforces a per-layer timeout, and reports status and cycle counts to the RISC-V control registers.

Parameters:
- NUM_LAYERS, 4, number of layer engines in the chain (2..16).
- LW, 4, width of the layer index; must satisfy 2**LW >= NUM_LAYERS.
- TIMEOUT_CYCLES, 2000000, maximum WAIT cycles per layer before the error state.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- go  in  1  run request pulse from the CPU; sampled only in IDLE.
- abort  in  1  cancels the run from any non-IDLE state.
- layer_mask  in  NUM_LAYERS  bit i=1 means layer i is enabled; latched on accepted go.
- layer_start  out  NUM_LAYERS  one-hot start pulse to the engines.
- layer_done  in  NUM_LAYERS  done pulses from the engines.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes normally.
- error  out  1  sticky timeout flag; cleared on the next accepted go.
- aborted  out  1  sticky abort flag; cleared on the next accepted go.
- cur_layer  out  LW  index of the layer currently examined or running.
- last_layer_cycles  out  32  WAIT-cycle count of the most recently completed layer.
- total_cycles  out  32  cycles from go acceptance to done, error or abort.

Behaviour:
- Reset (async, resetn=0): state=IDLE; all outputs 0; latched mask=0; counters=0.
- All state changes and outputs are registered on the rising edge of clk.
- States: IDLE, SELECT, START, WAIT, FINISH, ERR.
- IDLE:
  - go=1 latches layer_mask, sets cur_layer=0, total_cycles=0, error=0, aborted=0, and moves to SELECT.
  - go=0 holds IDLE; all status outputs hold their values.
- SELECT (examines one layer per cycle):
  - cur_layer==NUM_LAYERS goes to FINISH.
  - mask[cur_layer]=1 goes to START.
  - Otherwise cur_layer+1 and stay in SELECT.
- START: layer_start <= onehot(cur_layer), clear the layer counter, go to WAIT. layer_start is high exactly one cycle, the first WAIT cycle.
- WAIT:
  - layer counter increments every cycle.
  - layer_done[cur_layer]=1: last_layer_cycles <= counter+1, cur_layer+1, go to SELECT.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: error <= 1, go to ERR.
  - layer_done bits other than cur_layer are ignored in all states.
- FINISH: done <= 1 for one cycle, then IDLE.
- ERR: one cycle, then IDLE. done is not pulsed.
- total_cycles increments in every non-IDLE state, saturating at 0xFFFFFFFF.
- abort=1 in any non-IDLE state: next state IDLE, aborted <= 1, no done, layer_start forced to 0. The engines are not reset by this block.
- Simultaneous events in WAIT:
  - abort beats done.
  - done beats timeout on the same cycle.
- go while busy is ignored; mask changes while busy are ignored.
- Latency: go at cycle t gives layer_start[0] at t+3 when mask[0]=1. Each skipped layer adds 1 cycle.
- All-zero mask: done at t+NUM_LAYERS+2, no layer_start pulses.

Decomposition:
- Shared package cnn_ctrl_pkg holds:
  - the state encoding (localparam constants);
  - TIMEOUT_CYCLES default;
  - the layer index constants LAYER_POOL=0 and LAYER_DWPW=1.
- Optional sub-module cnn_sat_counter (32-bit saturating counter with clear and enable), used twice: per-layer and total.

Test Plan:
- Mask 4'b1111, each engine model returns done 10 cycles after its start -> layer_start shows 0001, 0010, 0100, 1000 in order; first pulse at go+3; last_layer_cycles=10; one done pulse; busy low afterward.
- Mask 4'b0101 -> only layer_start 0001 and 0100 are seen; layers 1 and 3 are skipped at 1 cycle each; done pulses once.
- Mask 4'b0000 -> no layer_start; done at go+6 (NUM_LAYERS=4).
- TIMEOUT_CYCLES=50, layer 1 never responds -> error=1 after 50 WAIT cycles; no done; IDLE; next go clears error.
- abort asserted 5 cycles into layer 2 WAIT, layer_done[2] in the same cycle -> IDLE, aborted=1, no done; a stray layer_done[3] pulse is ignored.
- resetn pulled low mid-WAIT asynchronously -> all outputs 0 immediately; go during busy and a layer_done[0] pulse while layer 2 is active are both ignored.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN layer scheduler: state encoding, default
// timeout and well-known layer indices.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSelect = 3'd1,
        StStart  = 3'd2,
        StWait   = 3'd3,
        StFinish = 3'd4,
        StErr    = 3'd5
    } sched_state_e;

    // Maximum WAIT cycles a layer may take before the run is flagged as hung.
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd2000000;

    // Fixed positions of the first engines in the chain.
    localparam int unsigned LAYER_POOL = 0;
    localparam int unsigned LAYER_DWPW = 1;

endpackage

// File: rtl/cnn_sat_counter.sv
// 32-bit up counter with synchronous clear and enable; sticks at all-ones.
module cnn_sat_counter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_d, count_q;

    // Next count: clear wins over enable, no wrap past all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Runs the CNN engine chain in index order for one inference: skips masked
// layers, pulses each enabled engine's start, waits for its done, times out
// hung layers and reports status and cycle counts.
module cnn_layer_scheduler
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = 4,
    parameter int unsigned LW             = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  go,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_mask,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  aborted,
    output logic [LW-1:0]         cur_layer,
    output logic [31:0]           last_layer_cycles,
    output logic [31:0]           total_cycles
);

    // One extra index bit so the "past the last layer" value always fits.
    localparam int unsigned IW = LW + 1;

    sched_state_e            state_d, state_q;
    logic [IW-1:0]           idx_d, idx_q;
    logic [NUM_LAYERS-1:0]   mask_d, mask_q;
    logic [NUM_LAYERS-1:0]   start_d, start_q;
    logic                    done_d, done_q;
    logic                    error_d, error_q;
    logic                    aborted_d, aborted_q;
    logic [31:0]             last_d, last_q;

    logic                    lay_clr, lay_en, tot_clr, tot_en;
    logic [31:0]             lay_cnt, tot_cnt;

    logic                    idx_end, sel_en, sel_done, timeout_hit;
    logic [NUM_LAYERS-1:0]   idx_onehot;

    cnn_sat_counter u_layer_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   (lay_clr),
        .en_i    (lay_en),
        .count_o (lay_cnt)
    );

    cnn_sat_counter u_total_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   (tot_clr),
        .en_i    (tot_en),
        .count_o (tot_cnt)
    );

    // Decode the current index against the latched mask and the done inputs.
    always_comb begin
        sel_en     = 1'b0;
        sel_done   = 1'b0;
        idx_onehot = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_en        = mask_q[i];
                sel_done      = layer_done[i];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign idx_end     = (idx_q == IW'(NUM_LAYERS));
    assign timeout_hit = (lay_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        start_d   = '0;
        done_d    = 1'b0;
        error_d   = error_q;
        aborted_d = aborted_q;
        last_d    = last_q;
        lay_clr   = 1'b0;
        lay_en    = 1'b0;
        tot_clr   = 1'b0;
        tot_en    = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    mask_d    = layer_mask;
                    idx_d     = IW'(LAYER_POOL);
                    error_d   = 1'b0;
                    aborted_d = 1'b0;
                    tot_clr   = 1'b1;
                    state_d   = StSelect;
                end
            end
            StSelect: begin
                if (idx_end) begin
                    // Registered so the pulse lines up with the FINISH cycle.
                    done_d  = 1'b1;
                    state_d = StFinish;
                end else if (sel_en) begin
                    state_d = StStart;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StStart: begin
                start_d = idx_onehot;
                lay_clr = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                lay_en = 1'b1;
                // Done is checked first so a done on the timeout cycle still counts.
                if (sel_done) begin
                    last_d  = lay_cnt + 32'd1;
                    idx_d   = idx_q + IW'(1);
                    state_d = StSelect;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = StErr;
                end
            end
            StFinish: state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if ((state_q != StIdle) && abort) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
            start_d   = '0;
            done_d    = 1'b0;
            error_d   = error_q;
            last_d    = last_q;
            idx_d     = idx_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            mask_q    <= '0;
            start_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            start_q   <= start_d;
            done_q    <= done_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
            last_q    <= last_d;
        end
    end

    assign layer_start       = start_q;
    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign error             = error_q;
    assign aborted           = aborted_q;
    assign cur_layer         = idx_q[LW-1:0];
    assign last_layer_cycles = last_q;
    assign total_cycles      = tot_cnt;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for cnn_layer_scheduler with simple engine models.
module tb_cnn_layer_scheduler;
    import cnn_ctrl_pkg::*;

    localparam int unsigned NL  = 4;
    localparam int unsigned LWP = 4;
    localparam int unsigned TO  = 50;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_mask = '0;
    logic [NL-1:0] layer_start;
    logic [NL-1:0] eng_done = '0;
    logic [NL-1:0] stray_done = '0;
    logic [NL-1:0] layer_done;
    logic          busy, done, error, aborted;
    logic [LWP-1:0] cur_layer;
    logic [31:0]   last_layer_cycles, total_cycles;

    assign layer_done = eng_done | stray_done;

    cnn_layer_scheduler #(
        .NUM_LAYERS     (NL),
        .LW             (LWP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .go                (go),
        .abort             (abort),
        .layer_mask        (layer_mask),
        .layer_start       (layer_start),
        .layer_done        (layer_done),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .aborted           (aborted),
        .cur_layer         (cur_layer),
        .last_layer_cycles (last_layer_cycles),
        .total_cycles      (total_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Engine models: done arrives in the Nth WAIT cycle after a start pulse.
    int eng_cnt[NL];
    int eng_delay[NL];
    bit eng_en[NL];
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            eng_done[i] = 1'b0;
            if (!resetn) begin
                eng_cnt[i] = 0;
            end else begin
                if (eng_cnt[i] > 0) begin
                    eng_cnt[i]--;
                    if (eng_cnt[i] == 0) eng_done[i] = 1'b1;
                end
                if (layer_start[i] && eng_en[i]) eng_cnt[i] = eng_delay[i] - 1;
            end
        end
    end

    // Monitor of start pulses and done pulses.
    logic [NL-1:0] start_val[$];
    int            start_at[$];
    int            done_cnt = 0;
    int            done_at = 0;
    always @(negedge clk) begin
        if (resetn) begin
            if (layer_start != '0) begin
                start_val.push_back(layer_start);
                start_at.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
        end
    end

    task automatic clear_logs();
        start_val.delete();
        start_at.delete();
        done_cnt = 0;
        done_at  = 0;
    endtask

    task automatic start_run(input logic [NL-1:0] m, output int g);
        @(posedge clk); #1;
        layer_mask = m;
        go = 1'b1;
        g = cyc;
        @(posedge clk); #1;
        go = 1'b0;
        layer_mask = ~m;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0 within 500 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, aborted} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, aborted});
        end
        checks++;
        if (layer_start !== '0) begin
            errors++;
            $display("FAIL reset_start: got %b expected 0000", layer_start);
        end
        checks++;
        if (cur_layer !== '0) begin
            errors++;
            $display("FAIL reset_cur: got %0d expected 0", cur_layer);
        end
        checks++;
        if (last_layer_cycles !== 32'd0 || total_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: got last=%0d total=%0d expected 0 0",
                     last_layer_cycles, total_cycles);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_all_layers();
        int g;
        logic [NL-1:0] exp_v;
        clear_logs();
        start_run(4'b1111, g);
        wait_idle("all");
        checks++;
        if (start_val.size() != 4) begin
            errors++;
            $display("FAIL all_start_count: got %0d expected 4", start_val.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_v = NL'(1) << k;
                checks++;
                if (start_val[k] !== exp_v || start_at[k] != g + 3 + 12 * k) begin
                    errors++;
                    $display("FAIL all_start_%0d: got %b@%0d expected %b@%0d",
                             k, start_val[k], start_at[k] - g, exp_v, 3 + 12 * k);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != g + 50) begin
            errors++;
            $display("FAIL all_done: got %0d pulses @%0d expected 1 @50", done_cnt, done_at - g);
        end
        checks++;
        if (last_layer_cycles !== 32'd10) begin
            errors++;
            $display("FAIL all_last_cycles: got %0d expected 10", last_layer_cycles);
        end
        checks++;
        if (total_cycles !== 32'd50) begin
            errors++;
            $display("FAIL all_total: got %0d expected 50", total_cycles);
        end
        checks++;
        if (cur_layer !== 4'd4 || error !== 1'b0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL all_status: got cur=%0d err=%b abt=%b expected 4 0 0",
                     cur_layer, error, aborted);
        end
    endtask

    task automatic test_skip();
        int g;
        clear_logs();
        start_run(4'b0101, g);
        wait_idle("skip");
        checks++;
        if (start_val.size() != 2) begin
            errors++;
            $display("FAIL skip_start_count: got %0d expected 2", start_val.size());
        end else begin
            checks++;
            if (start_val[0] !== 4'b0001 || start_at[0] != g + 3) begin
                errors++;
                $display("FAIL skip_start_0: got %b@%0d expected 0001@3",
                         start_val[0], start_at[0] - g);
            end
            checks++;
            if (start_val[1] !== 4'b0100 || start_at[1] != g + 16) begin
                errors++;
                $display("FAIL skip_start_1: got %b@%0d expected 0100@16",
                         start_val[1], start_at[1] - g);
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != g + 28) begin
            errors++;
            $display("FAIL skip_done: got %0d pulses @%0d expected 1 @28", done_cnt, done_at - g);
        end
        checks++;
        if (total_cycles !== 32'd28) begin
            errors++;
            $display("FAIL skip_total: got %0d expected 28", total_cycles);
        end
    endtask

    task automatic test_zero_mask();
        int g;
        clear_logs();
        start_run(4'b0000, g);
        wait_idle("zero");
        checks++;
        if (start_val.size() != 0) begin
            errors++;
            $display("FAIL zero_start_count: got %0d expected 0", start_val.size());
        end
        checks++;
        if (done_cnt != 1 || done_at != g + 6) begin
            errors++;
            $display("FAIL zero_done: got %0d pulses @%0d expected 1 @6", done_cnt, done_at - g);
        end
        checks++;
        if (total_cycles !== 32'd6) begin
            errors++;
            $display("FAIL zero_total: got %0d expected 6", total_cycles);
        end
    endtask

    task automatic test_timeout();
        int g;
        int g2;
        int n;
        int err_at;
        clear_logs();
        eng_en[LAYER_DWPW] = 1'b0;
        start_run(4'b1111, g);
        n = 0;
        while (error !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        err_at = cyc;
        checks++;
        if (error !== 1'b1 || err_at != g + 65) begin
            errors++;
            $display("FAIL tmo_error_rise: got err=%b @%0d expected 1 @65", error, err_at - g);
        end
        wait_idle("tmo");
        checks++;
        if (done_cnt != 0 || start_val.size() != 2) begin
            errors++;
            $display("FAIL tmo_pulses: got done=%0d starts=%0d expected 0 2",
                     done_cnt, start_val.size());
        end
        checks++;
        if (total_cycles !== 32'd65 || last_layer_cycles !== 32'd10) begin
            errors++;
            $display("FAIL tmo_counts: got total=%0d last=%0d expected 65 10",
                     total_cycles, last_layer_cycles);
        end
        checks++;
        if (error !== 1'b1 || cur_layer !== 4'd1) begin
            errors++;
            $display("FAIL tmo_sticky: got err=%b cur=%0d expected 1 1", error, cur_layer);
        end
        eng_en[LAYER_DWPW] = 1'b1;
        clear_logs();
        start_run(4'b0000, g2);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_go_clears: got err=%b busy=%b expected 0 1", error, busy);
        end
        wait_idle("tmo2");
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL tmo_rerun_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_abort();
        int g;
        clear_logs();
        eng_delay[2] = 6;
        start_run(4'b1111, g);
        wait_until(g + 29);
        stray_done = 4'b1000;
        @(posedge clk); #1;
        stray_done = '0;
        wait_until(g + 32);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b1 || layer_start !== '0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b abt=%b start=%b expected 0 1 0000",
                     busy, aborted, layer_start);
        end
        @(posedge clk); #1;
        stray_done = 4'b1000;
        @(posedge clk); #1;
        stray_done = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 0 || start_val.size() != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulses: got done=%0d starts=%0d busy=%b expected 0 3 0",
                     done_cnt, start_val.size(), busy);
        end
        checks++;
        if (last_layer_cycles !== 32'd10 || cur_layer !== 4'd2) begin
            errors++;
            $display("FAIL abort_beats_done: got last=%0d cur=%0d expected 10 2",
                     last_layer_cycles, cur_layer);
        end
        checks++;
        if (total_cycles !== 32'd32 || error !== 1'b0) begin
            errors++;
            $display("FAIL abort_total: got total=%0d err=%b expected 32 0", total_cycles, error);
        end
        eng_delay[2] = 10;
    endtask

    task automatic test_reset_mid_run();
        int g;
        clear_logs();
        start_run(4'b1111, g);
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL rst_go_clears_abort: got %b expected 0", aborted);
        end
        wait_until(g + 5);
        go = 1'b1;
        layer_mask = 4'b0000;
        @(posedge clk); #1;
        go = 1'b0;
        wait_until(g + 29);
        stray_done = 4'b0001;
        @(posedge clk); #1;
        stray_done = '0;
        wait_until(g + 42);
        @(negedge clk);
        checks++;
        if (start_val.size() != 4) begin
            errors++;
            $display("FAIL rst_start_count: got %0d expected 4", start_val.size());
        end else begin
            checks++;
            if (start_at[2] != g + 27 || start_val[3] !== 4'b1000 || start_at[3] != g + 39) begin
                errors++;
                $display("FAIL rst_ignored_inputs: got %b@%0d expected 1000@39",
                         start_val[3], start_at[3] - g);
            end
        end
        checks++;
        if (busy !== 1'b1 || last_layer_cycles !== 32'd10) begin
            errors++;
            $display("FAIL rst_pre_state: got busy=%b last=%0d expected 1 10",
                     busy, last_layer_cycles);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, aborted} !== 4'b0 || layer_start !== '0 || cur_layer !== '0) begin
            errors++;
            $display("FAIL rst_async_flags: got %b start=%b cur=%0d expected 0000 0000 0",
                     {busy, done, error, aborted}, layer_start, cur_layer);
        end
        checks++;
        if (last_layer_cycles !== 32'd0 || total_cycles !== 32'd0) begin
            errors++;
            $display("FAIL rst_async_counts: got last=%0d total=%0d expected 0 0",
                     last_layer_cycles, total_cycles);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL rst_post_idle: got busy=%b done=%0d expected 0 0", busy, done_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            eng_en[i]    = 1'b1;
            eng_delay[i] = 10;
            eng_cnt[i]   = 0;
        end
        test_reset();
        test_all_layers();
        test_skip();
        test_zero_mask();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
